// File: rtl/usb_tx_packet_sequencer.sv
// USB byte-level TX sequencer: SYNC, PID, payload, CRC16, then an EOP request.
// Optional underrun detection is compiled in when USB_TX_UNDERRUN_CHECK_EN is defined.
module usb_tx_packet_sequencer #(
  parameter int MAX_PACKET = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [2:0] tx_packet,
  input  logic [6:0] data_size,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  input  logic       byte_done,
  output logic       get_tx_packet_data,
  output logic [7:0] tx_byte,
  output logic       tx_byte_valid,
  output logic       send_eop,
  output logic       tx_busy,
  output logic       tx_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  byte_q, byte_d;
  logic        load;
  logic        occ_ok;
  logic [3:0]  pid;
  logic        type_valid;
  logic        type_is_data;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

`ifdef USB_TX_UNDERRUN_CHECK_EN
  assign occ_ok = (buffer_occupancy != '0);
`else
  logic unused_occupancy;
  assign unused_occupancy = ^buffer_occupancy;
  assign occ_ok = 1'b1;
`endif

  assign type_valid   = (tx_packet >= 3'd1) && (tx_packet <= 3'd5);
  assign type_is_data = (type_q == 3'd1) || (type_q == 3'd2);

  always_comb begin
    case (type_q)
      3'd1:    pid = 4'b0011;
      3'd2:    pid = 4'b1011;
      3'd3:    pid = 4'b0010;
      3'd4:    pid = 4'b1010;
      3'd5:    pid = 4'b1110;
      default: pid = 4'b0000;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    type_d             = type_q;
    cnt_d              = cnt_q;
    crc_d              = crc_q;
    byte_d             = byte_q;
    load               = 1'b0;
    get_tx_packet_data = 1'b0;
    tx_error           = 1'b0;

    case (state_q)
      S_IDLE: if (start && type_valid) begin
        type_d  = tx_packet;
        cnt_d   = (data_size > 7'(MAX_PACKET)) ? 7'(MAX_PACKET) : data_size;
        crc_d   = '1;
        byte_d  = 8'h80;
        state_d = S_SYNC;
      end
      S_SYNC: if (byte_done) begin
        byte_d  = {~pid, pid};
        state_d = S_PID;
      end
      S_PID: if (byte_done) begin
        if (!type_is_data) begin
          byte_d  = '0;
          state_d = S_EOP;
        end else if (cnt_q == '0) begin
          byte_d  = ~crc_q[7:0];
          state_d = S_CRC_LO;
        end else begin
          load = 1'b1;
        end
      end
      S_DATA: if (byte_done) begin
        if (cnt_q == '0) begin
          byte_d  = ~crc_q[7:0];
          state_d = S_CRC_LO;
        end else begin
          load = 1'b1;
        end
      end
      S_CRC_LO: if (byte_done) begin
        byte_d  = ~crc_q[15:8];
        state_d = S_CRC_HI;
      end
      S_CRC_HI: if (byte_done) begin
        byte_d  = '0;
        state_d = S_EOP;
      end
      S_EOP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Payload loads share one path whether entering DATA from PID or advancing within it.
    if (load) begin
      if (occ_ok) begin
        get_tx_packet_data = 1'b1;
        byte_d             = tx_packet_data;
        cnt_d              = cnt_q - 7'd1;
        crc_d              = crc16_byte(crc_q, tx_packet_data);
        state_d            = S_DATA;
      end else begin
        tx_error = 1'b1;
        byte_d   = '0;
        state_d  = S_EOP;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      cnt_q   <= '0;
      crc_q   <= '1;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      byte_q  <= byte_d;
    end
  end

  assign tx_byte       = byte_q;
  assign tx_byte_valid = (state_q != S_IDLE) && (state_q != S_EOP);
  assign send_eop      = (state_q == S_EOP);
  assign tx_busy       = (state_q != S_IDLE);

endmodule
